prefix_adder_pipe: RTL and testbench
====================================

PREFIX_ADDER_PIPE -- requirements
Module: prefix_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand/sum width in bits; legal 2..64.
REQ-002 Parameter STAGES, default 2: pipeline register stages from operands to result; legal 1..(ceil(log2(WIDTH))+1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 x  input  WIDTH  operand A.
REQ-008 y  input  WIDTH  operand B.
REQ-009 sub  input  1  0 = A+B, 1 = A-B.
REQ-010 ci  input  1  carry-in for add mode; ignored when sub=1.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 s  output  WIDTH  sum/difference.
REQ-014 co  output  1  carry out of MSB (sub mode: 1 = no borrow).
REQ-015 ov  output  1  two's-complement signed overflow.

Function
REQ-016 Sum SHALL be computed as x + y' + c0, with y' = sub ? ~y : y and c0 = sub ? 1 : ci, modulo 2^WIDTH.
REQ-017 Carries SHALL come from a parallel-prefix (generate/propagate) tree of ceil(log2(WIDTH)) levels; s[i] = h[i] XOR carry[i], h = x XOR y'.
REQ-018 co SHALL equal bit WIDTH of the full-width sum; ov SHALL equal carry into MSB XOR carry out of MSB.
REQ-019 STAGES registers SHALL be distributed across input-capture and prefix levels; each stage holds a valid bit plus its partial G/P/h data.
REQ-020 Transfer in: in_valid & in_ready; transfer out: out_valid & out_ready.
REQ-021 Global advance enable adv = out_ready | ~out_valid; in_ready SHALL equal adv (combinational, no dependency on in_valid).
REQ-022 When adv=1 every stage SHALL shift forward one step; stage-0 valid loads in_valid; when adv=0 all stages SHALL hold.
REQ-023 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no stall; throughput one result per cycle.
REQ-024 While out_valid=1 and out_ready=0, s/co/ov/out_valid SHALL remain stable.
REQ-025 Results SHALL emerge in acceptance order; no drop, no duplication; bubbles propagate (not collapsed).
REQ-026 s/co/ov SHALL be 0 whenever out_valid=0.
REQ-027 Operand values SHALL be sampled only on input transfer; x/y/sub/ci changes without transfer have no effect.

Reset
REQ-028 rst_n low SHALL immediately clear every stage valid bit and data register to 0; out_valid=0, s=0, co=0, ov=0.
REQ-029 in_ready SHALL read 1 during and after reset (out_valid=0).
REQ-030 Reset mid-operation SHALL discard all in-flight operations; none emerge after release.
REQ-031 First input transfer SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro PREFIX_ADDER_SAT_EN defined: on ov=1 s SHALL saturate to 0x7F..F (both operand MSBs 0, after y') or 0x80..0 (both 1); co and ov unchanged.
REQ-033 Macro undefined: s SHALL wrap modulo 2^WIDTH; no saturation logic present.

Verification (WIDTH=16, STAGES=2)
REQ-034 Reset: assert rst_n=0 mid-stream with 2 ops in flight -> out_valid=0, s=0, in_ready=1 immediately; no results after release.
REQ-035 Add: x=0xFFFF, y=0x0001, sub=0, ci=0 -> 2 cycles later s=0x0000, co=1, ov=0.
REQ-036 Overflow: x=0x7FFF, y=0x0001, sub=0 -> s=0x8000, co=0, ov=1; with PREFIX_ADDER_SAT_EN s=0x7FFF.
REQ-037 Subtract: x=0x0005, y=0x0007, sub=1 -> s=0xFFFE, co=0, ov=0; x=0x8000, y=0x0001, sub=1 -> s=0x7FFF, ov=1 (SAT_EN: 0x8000).
REQ-038 Backpressure: 4 back-to-back ops, out_ready=0 for 3 cycles after first out_valid -> in_ready=0, s held, then 4 results in order, no loss.
REQ-039 Random: 10^5 random x/y/sub/ci with random in_valid/out_ready against reference model -> zero mismatches for WIDTH in {2,6,16,33,64}.

Source files
------------

// File: rtl/prefix_adder_pipe.sv
// Pipelined parallel-prefix (Kogge-Stone) adder/subtractor with valid/ready handshake.
// Optional macro PREFIX_ADDER_SAT_EN: saturate s on signed overflow.
module prefix_adder_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    localparam int unsigned Levels = $clog2(WIDTH);

    // Number of prefix levels already applied to the data held in stage j.
    function automatic int unsigned done_lv(input int unsigned j);
        if (j == 0 || STAGES == 1) return 0;
        return (j * Levels) / (STAGES - 1);
    endfunction

    function automatic bit is_bnd(input int unsigned l);
        for (int unsigned j = 0; j < STAGES; j++) begin
            if (done_lv(j) == l) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int unsigned stage_at(input int unsigned l);
        for (int unsigned j = 0; j < STAGES; j++) begin
            if (done_lv(j) == l) return j;
        end
        return 0;
    endfunction

    logic             v_q  [STAGES];
    logic             v_d  [STAGES];
    logic [WIDTH-1:0] g_q  [STAGES];
    logic [WIDTH-1:0] g_d  [STAGES];
    logic [WIDTH-1:0] p_q  [STAGES];
    logic [WIDTH-1:0] p_d  [STAGES];
    logic [WIDTH-1:0] h_q  [STAGES];
    logic [WIDTH-1:0] h_d  [STAGES];
    logic             c0_q [STAGES];
    logic             c0_d [STAGES];

    logic             adv;
    logic [WIDTH-1:0] y_eff;
    logic             c0_in;
    logic [WIDTH-1:0] gen_in;
    logic [WIDTH-1:0] prop_in;
    logic [WIDTH-1:0] g_fin;

    assign out_valid = v_q[STAGES-1];
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;

    // Carry-in is folded into bit 0's generate so the tree yields carries directly.
    always_comb begin
        y_eff      = sub ? ~y : y;
        c0_in      = sub | ci;
        prop_in    = x ^ y_eff;
        gen_in     = x & y_eff;
        gen_in[0]  = gen_in[0] | (prop_in[0] & c0_in);
    end

    for (genvar l = 0; l < Levels; l++) begin : g_lvl
        localparam int Dist = 1 << l;
        logic [WIDTH-1:0] gi;
        logic [WIDTH-1:0] pi;
        logic [WIDTH-1:0] go;
        logic [WIDTH-1:0] po;

        if (is_bnd(l)) begin : g_src_reg
            assign gi = g_q[stage_at(l)];
            assign pi = p_q[stage_at(l)];
        end else begin : g_src_prev
            assign gi = g_lvl[(l > 0) ? l - 1 : 0].go;
            assign pi = g_lvl[(l > 0) ? l - 1 : 0].po;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= Dist) begin : g_cmb
                assign go[i] = gi[i] | (pi[i] & gi[i-Dist]);
                assign po[i] = pi[i] & pi[i-Dist];
            end else begin : g_pass
                assign go[i] = gi[i];
                assign po[i] = pi[i];
            end
        end
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_stage
        if (j == 0) begin : g_first
            // Bubbles carry zero data so nothing stale lingers in the pipe.
            assign v_d[0]  = in_valid;
            assign g_d[0]  = in_valid ? gen_in  : '0;
            assign p_d[0]  = in_valid ? prop_in : '0;
            assign h_d[0]  = in_valid ? prop_in : '0;
            assign c0_d[0] = in_valid & c0_in;
        end else begin : g_next
            assign v_d[j]  = v_q[j-1];
            assign g_d[j]  = g_lvl[done_lv(j)-1].go;
            assign p_d[j]  = g_lvl[done_lv(j)-1].po;
            assign h_d[j]  = h_q[j-1];
            assign c0_d[j] = c0_q[j-1];
        end
    end

    if (STAGES > 1) begin : g_fin_reg
        assign g_fin = g_q[STAGES-1];
    end else begin : g_fin_comb
        logic unused_p;
        assign g_fin    = g_lvl[Levels-1].go;
        assign unused_p = ^g_lvl[Levels-1].po;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < STAGES; j++) begin
                v_q[j]  <= 1'b0;
                g_q[j]  <= '0;
                p_q[j]  <= '0;
                h_q[j]  <= '0;
                c0_q[j] <= 1'b0;
            end
        end else if (adv) begin
            for (int unsigned j = 0; j < STAGES; j++) begin
                v_q[j]  <= v_d[j];
                g_q[j]  <= g_d[j];
                p_q[j]  <= p_d[j];
                h_q[j]  <= h_d[j];
                c0_q[j] <= c0_d[j];
            end
        end
    end

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] s_raw;
    logic [WIDTH-1:0] s_fix;
    logic             co_raw;
    logic             ov_raw;

    always_comb begin
        carry  = {g_fin[WIDTH-2:0], c0_q[STAGES-1]};
        s_raw  = h_q[STAGES-1] ^ carry;
        co_raw = g_fin[WIDTH-1];
        ov_raw = g_fin[WIDTH-1] ^ g_fin[WIDTH-2];
        s_fix  = s_raw;
`ifdef PREFIX_ADDER_SAT_EN
        // On overflow the wrapped sign is the opposite of the operands' common sign.
        if (ov_raw) begin
            s_fix = s_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
        s  = out_valid ? s_fix  : '0;
        co = out_valid & co_raw;
        ov = out_valid & ov_raw;
    end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Self-checking bench for prefix_adder_pipe: directed vectors, backpressure, reset, random traffic.
module tb_prefix_adder_pipe;

    localparam int W = 16;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         sub;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co;
    logic         ov;

    int n_tot  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_out  = 0;
    logic [W+1:0] exp_q [$];

    always #5 clk = ~clk;

    prefix_adder_pipe #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .sub       (sub),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ov        (ov)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tot++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic, result packed as {s, co, ov}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sb, input logic c);
        logic [W-1:0] bp;
        logic [W:0]   full;
        logic [W-1:0] r;
        logic         v;
        bp   = sb ? ~b : b;
        full = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, (sb | c)};
        r    = full[W-1:0];
        v    = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
`ifdef PREFIX_ADDER_SAT_EN
        if (v) r = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return {r, full[W], v};
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return 16'($urandom());
        endcase
    endfunction

    // Sample one cycle's outputs mid-cycle and update the scoreboard.
    task automatic tick();
        #1;
        if (in_valid && in_ready) exp_q.push_back(model(x, y, sub, ci));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                chk("result", 64'({s, co, ov}), 64'(exp_q[0]));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end else begin
            chk("idle_zero", 64'({s, co, ov}), 64'd0);
        end
    endtask

    task automatic dir_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb,
                          input logic c, input logic [W+1:0] expv, input string tag);
        in_valid  = 1'b1;
        x         = a;
        y         = b;
        sub       = sb;
        ci        = c;
        out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x        = ~a;
        y        = ~b;
        chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk(tag, 64'({s, co, ov}), 64'(expv));
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [W-1:0] bp_x [4];
    logic [W-1:0] bp_y [4];
    int sent;
    int n0;

    initial begin
        bp_x = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0F0F};
        bp_y = '{16'h1111, 16'h0002, 16'h0001, 16'hF0F0};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        sub       = 1'b0;
        ci        = 1'b0;
        out_ready = 1'b1;

        @(negedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_s", 64'(s), 64'd0);
        chk("reset_co_ov", 64'({co, ov}), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        @(negedge clk);
        rst_n = 1'b1;
        dir_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0}, "add_wrap");
        dir_op(16'h1234, 16'h4321, 1'b0, 1'b1, {16'h5556, 1'b0, 1'b0}, "add_ci");
`ifdef PREFIX_ADDER_SAT_EN
        dir_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h7FFF, 1'b0, 1'b1}, "add_ovf");
        dir_op(16'h8000, 16'h0001, 1'b1, 1'b0, {16'h8000, 1'b1, 1'b1}, "sub_ovf");
`else
        dir_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1}, "add_ovf");
        dir_op(16'h8000, 16'h0001, 1'b1, 1'b0, {16'h7FFF, 1'b1, 1'b1}, "sub_ovf");
`endif
        dir_op(16'h0005, 16'h0007, 1'b1, 1'b0, {16'hFFFE, 1'b0, 1'b0}, "sub_borrow");
        dir_op(16'h0007, 16'h0005, 1'b1, 1'b0, {16'h0002, 1'b1, 1'b0}, "sub_noborrow");

        // Backpressure: downstream stalls for three cycles once the first result shows.
        sent = 0;
        n0   = n_out;
        for (int c = 0; c < 12; c++) begin
            in_valid  = (sent < 4);
            x         = bp_x[sent % 4];
            y         = bp_y[sent % 4];
            sub       = 1'b0;
            ci        = 1'b0;
            out_ready = !(c >= 2 && c <= 4);
            tick();
            if (c >= 2 && c <= 4) begin
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_out_valid", 64'(out_valid), 64'd1);
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        chk("bp_sent", 64'(sent), 64'd4);
        chk("bp_count", 64'(n_out - n0), 64'd4);

        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            x         = rnd_op();
            y         = rnd_op();
            sub       = 1'($urandom_range(0, 1));
            ci        = 1'($urandom_range(0, 1));
            tick();
            @(negedge clk);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            @(negedge clk);
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        // Reset with two operations in flight: none may emerge afterwards.
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            x        = rnd_op();
            y        = rnd_op();
            tick();
            @(negedge clk);
        end
        in_valid = 1'b0;
        tick();
        chk("rst_inflight", 64'(exp_q.size()), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_s", 64'(s), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        n0 = n_out;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            @(negedge clk);
        end
        chk("rst_no_output", 64'(n_out - n0), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
